// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum datapath (adder stage and block accumulator).
//   SUM_W        : width of the unsigned sum produced by the adder stage.
//   acc_state_e  : block accumulator FSM states.
package sum_accumulator_pkg;

  localparam int SUM_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

endpackage : sum_accumulator_pkg

// File: rtl/sum_accumulator.sv
// Block accumulator: sums BLOCK_LEN consecutive unsigned beats from the adder
// stage and presents the block total and its truncated mean through a
// valid/ready output. Back-to-back blocks run without a bubble.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   sum_i        : unsigned sum beat (SUM_W bits)
//   sum_valid_i  : sum_i carries a beat
//   sum_ready_o  : beat is accepted this cycle when sum_valid_i is also high
//   clear_i      : synchronous abort of the current block (beats the handshakes)
//   acc_o        : block total (ACC_W bits)
//   mean_o       : acc_o >> log2(BLOCK_LEN), truncated
//   acc_valid_o  : acc_o / mean_o hold a complete block result
//   acc_ready_i  : downstream takes the result
//   blk_cnt_o    : number of results delivered, wraps at 16 bits
//
// BLOCK_LEN must be a power of two in 2..256.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int BLOCK_LEN = 8,
  localparam int LOG2_LEN = $clog2(BLOCK_LEN),
  localparam int ACC_W    = SUM_W + LOG2_LEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SUM_W-1:0] sum_i,
  input  logic             sum_valid_i,
  output logic             sum_ready_o,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [SUM_W-1:0] mean_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [15:0]      blk_cnt_o
);

  // The beat counter wraps to zero on the last beat of a block, so
  // log2(BLOCK_LEN) bits are enough.
  localparam int CNT_W = LOG2_LEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [15:0]      blk_q,   blk_d;
  logic             ready_c;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    ready_c = 1'b0;

    if (clear_i) begin
      // Abort wins over every handshake: nothing is accepted or delivered.
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          ready_c = 1'b1;
          if (sum_valid_i) begin
            acc_d   = ACC_W'(sum_i);
            cnt_d   = CNT_W'(1);
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          ready_c = 1'b1;
          if (sum_valid_i) begin
            acc_d = acc_q + ACC_W'(sum_i);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Input is only taken while the result drains, so a new block can
          // start in the very cycle the old one leaves.
          ready_c = acc_ready_i;
          if (acc_ready_i) begin
            blk_d = blk_q + 16'd1;
            if (sum_valid_i) begin
              acc_d   = ACC_W'(sum_i);
              cnt_d   = CNT_W'(1);
              state_d = ST_ACCUM;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

  assign sum_ready_o = ready_c & ~rst_i;
  assign acc_valid_o = (state_q == ST_HOLD);
  assign acc_o       = acc_q;
  assign mean_o      = acc_q[ACC_W-1:LOG2_LEN];
  assign blk_cnt_o   = blk_q;

endmodule : sum_accumulator

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 8, number of sums per block; power of two, range 2..256.
REQ-002 SHALL have derived localparam ACC_W = 17 + log2(BLOCK_LEN), accumulator width; default 20.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port sum_i  input  17  unsigned sum from the upstream adder stage.
REQ-006 SHALL have port sum_valid_i  input  1  sum_i carries a valid beat.
REQ-007 SHALL have port sum_ready_o  output  1  block accepts sum_i this cycle.
REQ-008 SHALL have port clear_i  input  1  synchronous abort of the current block.
REQ-009 SHALL have port acc_o  output  ACC_W  block total.
REQ-010 SHALL have port mean_o  output  17  block mean, acc_o >> log2(BLOCK_LEN), truncated.
REQ-011 SHALL have port acc_valid_o  output  1  acc_o/mean_o are valid.
REQ-012 SHALL have port acc_ready_i  input  1  downstream accepts the result.
REQ-013 SHALL have port blk_cnt_o  output  16  count of completed output handshakes; wraps 0xFFFF->0.

Function
REQ-014 SHALL accept a beat only when sum_valid_i && sum_ready_o are both high in the same cycle.
REQ-015 SHALL deliver a result only when acc_valid_o && acc_ready_i are both high in the same cycle.
REQ-016 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-017 SHALL, in IDLE, drive sum_ready_o=1; an accepted beat loads acc=sum_i, sets beat count=1 and moves to ACCUM.
REQ-018 SHALL, in ACCUM, drive sum_ready_o=1; an accepted beat adds into acc and increments the count.
REQ-019 SHALL move from ACCUM to HOLD on the BLOCK_LEN-th accepted beat, with acc_valid_o=1 on the next cycle.
REQ-020 SHALL, in HOLD, hold acc_o, mean_o and acc_valid_o stable until the output handshake.
REQ-021 SHALL, in HOLD, drive sum_ready_o = acc_ready_i.
REQ-022 SHALL, on an output handshake with no beat accepted, go to IDLE and drive acc_valid_o=0 next cycle.
REQ-023 SHALL, on an output handshake with a beat accepted in the same cycle, load acc=sum_i, set count=1 and go to ACCUM (zero-bubble back-to-back blocks).
REQ-024 SHALL increment blk_cnt_o on each output handshake.
REQ-025 SHALL give clear_i priority over all handshakes: when clear_i=1, sum_ready_o=0.
REQ-026 SHALL, on clear_i, discard the partial or pending result, go to IDLE, zero acc and count, and drive acc_valid_o=0 next cycle; blk_cnt_o is unchanged.
REQ-027 SHALL never overflow the accumulator; ACC_W covers BLOCK_LEN*(2^17-1).
REQ-028 SHALL have latency of one cycle from the last accepted beat to acc_valid_o=1.
REQ-029 SHALL never drive acc_valid_o=1 for a partial block.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, set state=IDLE, acc_o=0, mean_o=0, acc_valid_o=0, count=0 and blk_cnt_o=0.
REQ-031 SHALL drive sum_ready_o=0 while rst_i=1.
REQ-032 SHALL, on reset mid-block or in HOLD, discard all data, with no result emitted afterwards.

Structure
REQ-033 SHALL place the FSM state enumeration and the 17-bit sum width constant in the shared project package, also used by the adder stage.
REQ-034 SHALL be a single module with no sub-module; the count and blk_cnt_o are inline counters.

Verification (BLOCK_LEN=4)
REQ-035 SHALL cover: beats 1,2,3,4 with acc_ready_i=1 -> acc_o=10, mean_o=2, acc_valid_o high one cycle after 4th beat, blk_cnt_o=1.
REQ-036 SHALL cover: four beats of 0x1FFFF -> acc_o=0x7FFFC, mean_o=0x1FFFF, no overflow.
REQ-037 SHALL cover: acc_ready_i=0 for 5 cycles after result -> acc_o stable, sum_ready_o=0, no beat lost; the beat offered at release starts the next block.
REQ-038 SHALL cover: 8 continuous beats 1..8 with acc_ready_i=1 -> results 10 then 26 and no idle cycle on sum_ready_o.
REQ-039 SHALL cover: clear_i after 2 beats, then beats 5,5,5,5 -> single result acc_o=20, blk_cnt_o=1.
REQ-040 SHALL cover: rst_i asserted in HOLD -> acc_valid_o=0, acc_o=0, blk_cnt_o=0 next cycle.
